// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if
// Bundles the fetch lookup, memory request/response and cache fill signals
// of the instruction-cache refill controller.
//   master : the refill controller (drives stall, mem request, fill, counters)
//   slave  : the surroundings (fetch stage, cache tags, backing memory)
// Parameters: DATA_WIDTH (word width), ADDR_WIDTH (byte-address width).
interface icache_refill_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  lookup_valid;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  hit;
  logic                  stall;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_done;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport master (
    input  lookup_valid, lookup_addr, hit, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output stall, mem_req_valid, mem_req_addr, fill_we, fill_addr, fill_data,
           fill_done, hit_count, miss_count
  );

  modport slave (
    output lookup_valid, lookup_addr, hit, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  stall, mem_req_valid, mem_req_addr, fill_we, fill_addr, fill_data,
           fill_done, hit_count, miss_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Miss-handling controller for a direct-mapped instruction cache. On a fetch
// miss it stalls fetch, requests the whole line from memory, writes each
// returned beat into the cache and releases the stall once the line is in.
// Ports:
//   clk    : core clock
//   reset  : asynchronous, active-low reset
//   bus    : icache_refill_ctrl_if.master (lookup, mem req/rsp, fill, counters)
// Optional feature: define ICACHE_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise hit_count and miss_count are tied to zero.
//
// state | meaning
// IDLE  | watching lookups; a miss latches the line base
// REQ   | line request held on the memory request channel until accepted
// FILL  | writing response beats into the cache, ascending word order
// DONE  | one-cycle fill_done pulse, then back to IDLE for the retry
module icache_refill_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                clk,
  input  logic                reset,
  icache_refill_ctrl_if.master bus
);

  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [BEAT_W-1:0]     beat;
  logic                  mem_req_valid_q;
  logic                  fill_done_q;
  logic                  miss_seen;
  logic                  hit_seen;
  logic                  fill_we_c;

  assign miss_seen = (state == IDLE) && bus.lookup_valid && !bus.hit;
  assign hit_seen  = (state == IDLE) && bus.lookup_valid && bus.hit;
  assign fill_we_c = (state == FILL) && bus.mem_rsp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      line_base       <= '0;
      beat            <= '0;
      mem_req_valid_q <= 1'b0;
      fill_done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_seen) begin
            line_base       <= bus.lookup_addr & LINE_MASK;
            beat            <= '0;
            mem_req_valid_q <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_rsp_valid) begin
            // counter is exactly log2 wide, so the last beat wraps it to 0
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              fill_done_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          fill_done_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // combinational so the missing PC is held in the very cycle it misses
  assign bus.stall         = (state != IDLE) || miss_seen;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = line_base;
  assign bus.fill_we       = fill_we_c;
  assign bus.fill_addr     = fill_we_c ? (line_base | (ADDR_WIDTH'(beat) << 2)) : '0;
  assign bus.fill_data     = fill_we_c ? bus.mem_rsp_data : {DATA_WIDTH{1'b0}};
  assign bus.fill_done     = fill_done_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_seen && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_seen && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  logic unused_hit_seen;
  assign unused_hit_seen = hit_seen;
  assign bus.hit_count   = 32'd0;
  assign bus.miss_count  = 32'd0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int WPL = 4;
`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  icache_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  int done_pulses = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every fill write must match the next expected {addr,data}
  always @(negedge clk) begin
    if (bus.stall === 1'b1) stall_cycles++;
    if (bus.fill_done === 1'b1) done_pulses++;
    if (bus.fill_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("fill_unexpected", 64'(bus.fill_we), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("fill_word", {bus.fill_addr, bus.fill_data}, mon_exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_hit_count"}, bus.hit_count, PERF ? exp_hits : 0);
    chk({tag, "_miss_count"}, bus.miss_count, PERF ? exp_misses : 0);
  endtask

  // caller is at posedge+1 with fetch idle
  task automatic do_miss(input logic [31:0] addr, input int ready_delay, input int gap,
                         input bit spurious, input logic [31:0] dbase);
    logic [31:0] base;
    base = addr & ~32'hF;
    stall_cycles = 0;
    done_pulses  = 0;
    bus.lookup_valid = 1'b1;
    bus.hit          = 1'b0;
    bus.lookup_addr  = addr;
    @(negedge clk);
    chk("detect_stall", bus.stall, 1);
    chk("detect_req_low", bus.mem_req_valid, 0);
    cyc();
    exp_misses++;
    if (spurious) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
    end
    for (int i = 0; i < ready_delay; i++) begin
      bus.mem_req_ready = 1'b0;
      @(negedge clk);
      chk("wait_req_valid", bus.mem_req_valid, 1);
      chk("wait_req_addr", bus.mem_req_addr, base);
      chk("wait_stall", bus.stall, 1);
      cyc();
      bus.mem_rsp_valid = 1'b0;
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", bus.mem_req_valid, 1);
    chk("req_addr", bus.mem_req_addr, base);
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    for (int b = 0; b < WPL; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_done_low", bus.fill_done, 0);
          chk("gap_stall", bus.stall, 1);
          cyc();
        end
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = dbase + 32'(b);
      exp_q.push_back({base | 32'(b * 4), dbase + 32'(b)});
      @(negedge clk);
      chk("beat_done_low", bus.fill_done, 0);
      cyc();
      bus.mem_rsp_valid = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", bus.fill_done, 1);
    chk("done_stall", bus.stall, 1);
    cyc();
    bus.hit = 1'b1;
    @(negedge clk);
    chk("release_stall", bus.stall, 0);
    chk("done_cleared", bus.fill_done, 0);
    chk("idle_req_low", bus.mem_req_valid, 0);
    cyc();
    exp_hits++;
    bus.lookup_valid = 1'b0;
    bus.hit          = 1'b0;
    chk("stall_cycles", 64'(stall_cycles), 64'(3 + WPL + ready_delay + gap * (WPL - 1)));
    chk("done_pulses", 64'(done_pulses), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk_counters("miss");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, bus.stall, 0);
    chk({tag, "_req_valid"}, bus.mem_req_valid, 0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 0);
    chk({tag, "_fill_we"}, bus.fill_we, 0);
    chk({tag, "_fill_addr"}, bus.fill_addr, 0);
    chk({tag, "_fill_data"}, bus.fill_data, 0);
    chk({tag, "_fill_done"}, bus.fill_done, 0);
    chk_counters(tag);
  endtask

  initial begin
    bus.lookup_valid  = 1'b0;
    bus.lookup_addr   = '0;
    bus.hit           = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    #1;
    chk_reset_outputs("reset");
    cyc();
    reset = 1'b1;
    cyc();

    // ten back-to-back hits
    bus.lookup_valid = 1'b1;
    bus.hit          = 1'b1;
    bus.lookup_addr  = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hit_stall", bus.stall, 0);
      chk("hit_req", bus.mem_req_valid, 0);
      cyc();
    end
    exp_hits = 10;
    bus.lookup_valid = 1'b0;
    bus.hit          = 1'b0;
    chk_counters("hits");

    do_miss(32'h0000_0104, 0, 0, 1'b0, 32'h0000_00A0);
    do_miss(32'h0000_2FFC, 5, 0, 1'b0, 32'h0000_00B0);
    do_miss(32'h0000_0508, 0, 2, 1'b1, 32'h0000_00C0);

    // reset while the second beat is on the bus
    bus.lookup_valid = 1'b1;
    bus.hit          = 1'b0;
    bus.lookup_addr  = 32'h0000_0230;
    cyc();
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_00E0;
    exp_q.push_back({32'h0000_0230, 32'h0000_00E0});
    cyc();
    bus.mem_rsp_data = 32'h0000_00E1;
    #2;
    reset = 1'b0;
    bus.lookup_valid = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    #1;
    chk_reset_outputs("midfill");
    bus.mem_rsp_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    do_miss(32'h0000_0234, 0, 0, 1'b0, 32'h0000_00D0);

    cyc();
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the pipelined core's direct-mapped instruction cache. It watches each fetch lookup and, on a miss, stalls the fetch stage. It then requests the full cache line from backing instruction memory over a valid/ready handshake and writes the returned beats into the cache. It releases the stall once the line is resident, so the retried lookup hits.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction/word width in bits
- ADDR_WIDTH, 32, byte-address width
- WORDS_PER_LINE, 4, words per cache line; power of two, at least 2

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- lookup_valid  in  1  fetch is presenting a PC to the cache this cycle
- lookup_addr  in  ADDR_WIDTH  fetch PC (byte address, word aligned)
- hit  in  1  cache hit indication for lookup_addr
- stall  out  1  high: hold the PC and the IF/ID register (fetch enable = ~stall)
- mem_req_valid  out  1  line request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_WIDTH  line-aligned base address
- mem_rsp_valid  in  1  one response beat valid
- mem_rsp_data  in  DATA_WIDTH  response beat, in ascending word order
- fill_we  out  1  cache write enable
- fill_addr  out  ADDR_WIDTH  byte address of the word being written
- fill_data  out  DATA_WIDTH  word being written
- fill_done  out  1  one-cycle pulse after the last beat is written
- hit_count  out  32  hit counter (see Configuration)
- miss_count  out  32  miss counter (see Configuration)

## Operation
- States: IDLE, REQ, FILL, DONE; 2-bit encoded; reset state is IDLE.
- IDLE:
  - lookup_valid & ~hit latches line_base = lookup_addr with the low log2(WORDS_PER_LINE)+2 bits cleared.
  - Clears beat counter; next state REQ.
  - lookup_valid & hit: stays IDLE.
- REQ:
  - mem_req_valid=1 and mem_req_addr=line_base, held stable until accepted.
  - mem_req_valid & mem_req_ready moves to FILL.
- FILL:
  - Each mem_rsp_valid drives fill_we=1, fill_data=mem_rsp_data, fill_addr=line_base | (beat<<2), and increments beat.
  - The beat with beat==WORDS_PER_LINE-1 moves to DONE.
- DONE: fill_done=1 for exactly one cycle, then IDLE.
- beat counter is $clog2(WORDS_PER_LINE) bits; it wraps to 0 on the final beat, with no overflow state.
- stall = (state!=IDLE) | (state==IDLE & lookup_valid & ~hit). It is combinational, so the missing PC is never advanced past.
- mem_rsp_valid outside FILL is ignored: no write, and the counter is unchanged.
- lookup_valid/hit/lookup_addr are ignored outside IDLE; only one miss is outstanding.
- A miss presented during DONE is not observed. The retried lookup is re-evaluated in IDLE on the following cycle.
- Reset asserted mid-refill:
  - state returns to IDLE and beat to 0 immediately, and all outputs drop.
  - Any partially written line is left to the cache's own valid bits; this block does not invalidate.

## Timing
- Reset values: stall=0 (unless the IDLE miss condition holds), mem_req_valid=0, mem_req_addr=0, fill_we=0, fill_addr=0, fill_data=0, fill_done=0, hit_count=0, miss_count=0.
- Miss detection to mem_req_valid: 1 cycle (REQ entered on the next edge).
- Fill writes are combinational from mem_rsp_valid/mem_rsp_data, written in the same cycle the beat arrives.
- Minimum miss penalty, with mem_req_ready high in REQ and back-to-back beats, is WORDS_PER_LINE+3 stall cycles:
  - 1 IDLE-detect cycle
  - 1 REQ cycle
  - WORDS_PER_LINE FILL cycles
  - 1 DONE cycle
- The first unstalled cycle re-presents the same PC and must hit.
- Gaps between response beats extend FILL and are not an error.

## Configuration
- ICACHE_PERF_CNT_EN defined:
  - hit_count increments on each IDLE cycle with lookup_valid & hit.
  - miss_count increments on each IDLE→REQ transition.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared only by reset.
- Not defined: no counter registers are built; hit_count and miss_count are tied to 0.

## Test plan
- Reset, then lookup_valid=1, hit=1 for 10 cycles -> stall stays 0, no mem_req_valid, hit_count=10 (with macro).
- Miss at lookup_addr=0x0000_0104, mem_req_ready=1, 4 consecutive beats 0xA0..0xA3 -> mem_req_addr=0x0000_0100, writes at 0x100/0x104/0x108/0x10C with those data, fill_done 1 cycle, stall high exactly 7 cycles, miss_count=1.
- Miss with mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable all 5 cycles, no fill_we, stall held.
- Beats separated by 2-cycle gaps plus a spurious mem_rsp_valid during REQ -> spurious beat ignored, four writes in order, DONE only after fourth beat.
- Reset asserted on the second FILL beat -> all outputs reach reset values asynchronously. After release, the next miss starts cleanly at beat 0.
- Build without ICACHE_PERF_CNT_EN, run the miss scenario -> hit_count=miss_count=0 throughout, refill behaviour identical.
